// File: rtl/ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ctrl_pkg : opcode, ALU-op and state constants for multicycle_ctrl   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package ctrl_pkg;

  localparam logic [6:0] OP_RTYPE   = 7'b0110011;
  localparam logic [6:0] OP_ITYPE   = 7'b0010011;
  localparam logic [6:0] FUNCT7_MUL = 7'b0000001;

  localparam logic [1:0] ALU_OP_NONE = 2'b00;
  localparam logic [1:0] ALU_OP_R    = 2'b10;
  localparam logic [1:0] ALU_OP_I    = 2'b11;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MULW   = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

endpackage
`default_nettype wire

// File: rtl/opcode_decode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | opcode_decode : combinational IR classifier for the RV32 sequencer  |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module opcode_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic        legal_o,
  output logic        is_nop_halt_o,
  output logic        is_mul_o,
  output logic [1:0]  alu_op_o,
  output logic        alu_src_o
);

  always_comb begin
    legal_o       = 1'b0;
    is_mul_o      = 1'b0;
    alu_op_o      = ALU_OP_NONE;
    alu_src_o     = 1'b0;
    is_nop_halt_o = (ir_i == 32'h0000_0000);
    case (ir_i[6:0])
      OP_RTYPE: begin
        legal_o  = 1'b1;
        alu_op_o = ALU_OP_R;
        is_mul_o = (ir_i[31:25] == FUNCT7_MUL);
      end
      OP_ITYPE: begin
        legal_o   = 1'b1;
        alu_op_o  = ALU_OP_I;
        alu_src_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | multicycle_ctrl : fetch/decode/exec/mul-wait/writeback sequencer    |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             halt_req_i,
  output logic             imem_req_o,
  input  logic             imem_ack_i,
  input  logic [31:0]      instr_i,
  output logic             ir_en_o,
  output logic [1:0]       alu_op_o,
  output logic             alu_src_o,
  output logic             mul_start_o,
  input  logic             mul_done_i,
  output logic             reg_write_o,
  output logic             pc_en_o,
  output logic [2:0]       state_o,
  output logic             illegal_o,
  output logic             fetch_err_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  localparam int             TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             fetch_err_q, fetch_err_d;

  logic       dec_legal, dec_nop_halt, dec_is_mul, dec_alu_src;
  logic [1:0] dec_alu_op;

  opcode_decode u_decode (
    .ir_i          (ir_q),
    .legal_o       (dec_legal),
    .is_nop_halt_o (dec_nop_halt),
    .is_mul_o      (dec_is_mul),
    .alu_op_o      (dec_alu_op),
    .alu_src_o     (dec_alu_src)
  );

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    tmo_d       = '0;
    cnt_d       = cnt_q;
    illegal_d   = illegal_q;
    fetch_err_d = fetch_err_q;
    imem_req_o  = 1'b0;
    ir_en_o     = 1'b0;
    mul_start_o = 1'b0;
    reg_write_o = 1'b0;
    pc_en_o     = 1'b0;
    alu_op_o    = ALU_OP_NONE;
    alu_src_o   = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_FETCH;
      S_FETCH: begin
        imem_req_o = 1'b1;
        tmo_d      = tmo_q + 1'b1;
        // An ack arriving in the final allowed cycle takes priority over the timeout.
        if (imem_ack_i) begin
          ir_en_o = 1'b1;
          ir_d    = instr_i;
          state_d = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          fetch_err_d = 1'b1;
          state_d     = S_HALT;
        end
      end
      S_DECODE: begin
        if (dec_nop_halt) begin
          state_d = S_HALT;
        end else if (dec_legal) begin
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_EXEC: begin
        alu_op_o  = dec_alu_op;
        alu_src_o = dec_alu_src;
        if (dec_is_mul) begin
          mul_start_o = 1'b1;
          state_d     = S_MULW;
        end else begin
          state_d = S_WB;
        end
      end
      S_MULW: begin
        alu_op_o  = dec_alu_op;
        alu_src_o = dec_alu_src;
        if (mul_done_i) state_d = S_WB;
      end
      S_WB: begin
        alu_op_o    = dec_alu_op;
        alu_src_o   = dec_alu_src;
        reg_write_o = 1'b1;
        pc_en_o     = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        state_d = halt_req_i ? S_IDLE : S_FETCH;
      end
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      tmo_q       <= '0;
      cnt_q       <= '0;
      illegal_q   <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      tmo_q       <= tmo_d;
      cnt_q       <= cnt_d;
      illegal_q   <= illegal_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign state_o     = state_q;
  assign illegal_o   = illegal_q;
  assign fetch_err_o = fetch_err_q;
  assign instr_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_multicycle_ctrl : directed self-checking bench for the sequencer |
// | Revision           : 1.0                                           |
// +--------------------------------------------------------------------+
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1, start = 1'b0, halt_req = 1'b0, imem_ack = 1'b0, mul_done = 1'b0;
  logic [31:0] instr = '0;

  logic        imem_req, ir_en, alu_src, mul_start, reg_write, pc_en, illegal, fetch_err;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic [15:0] cnt;

  logic        imem_req_s, ir_en_s, alu_src_s, mul_start_s, reg_write_s, pc_en_s, illegal_s, fetch_err_s;
  logic [1:0]  alu_op_s;
  logic [2:0]  state_s;
  logic [1:0]  cnt_s;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] ADD  = 32'h0020_81B3;
  localparam logic [31:0] MUL  = 32'h0220_81B3;
  localparam logic [31:0] BAD  = 32'h0000_007F;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(16), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .halt_req_i(halt_req),
    .imem_req_o(imem_req), .imem_ack_i(imem_ack), .instr_i(instr), .ir_en_o(ir_en),
    .alu_op_o(alu_op), .alu_src_o(alu_src), .mul_start_o(mul_start), .mul_done_i(mul_done),
    .reg_write_o(reg_write), .pc_en_o(pc_en), .state_o(state), .illegal_o(illegal),
    .fetch_err_o(fetch_err), .instr_cnt_o(cnt)
  );

  multicycle_ctrl #(.TIMEOUT(16), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start), .halt_req_i(halt_req),
    .imem_req_o(imem_req_s), .imem_ack_i(imem_ack), .instr_i(instr), .ir_en_o(ir_en_s),
    .alu_op_o(alu_op_s), .alu_src_o(alu_src_s), .mul_start_o(mul_start_s), .mul_done_i(mul_done),
    .reg_write_o(reg_write_s), .pc_en_o(pc_en_s), .state_o(state_s), .illegal_o(illegal_s),
    .fetch_err_o(fetch_err_s), .instr_cnt_o(cnt_s)
  );

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    nxt();
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; mul_done = 1'b0; instr = '0;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  // Starts in FETCH at a falling edge; leaves one cycle after WB (FETCH or IDLE).
  task automatic do_instr(input logic [31:0] ins, input logic hr);
    imem_ack = 1'b1; instr = ins;
    nxt(); imem_ack = 1'b0;
    nxt();
    nxt(); halt_req = hr;
    nxt(); halt_req = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut(); #1;
    n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if ({imem_req, ir_en, alu_op, alu_src, mul_start, reg_write, pc_en} !== 8'h00) begin
      n_err++; $display("FAIL reset_strobes: got %b want 00000000", {imem_req, ir_en, alu_op, alu_src, mul_start, reg_write, pc_en}); end
    n_cmp++; if ({illegal, fetch_err} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {illegal, fetch_err}); end
    n_cmp++; if (cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    n_cmp++; if (cnt_s !== 2'd0) begin n_err++; $display("FAIL reset_cnt_sat: got %0d want 0", cnt_s); end
  endtask

  task automatic test_addi();
    reset_dut(); start = 1'b1;
    nxt(); start = 1'b0; #1;
    n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL addi_fetch_state: got %0d want 1", state); end
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL addi_imem_req: got %b want 1", imem_req); end
    n_cmp++; if (ir_en !== 1'b0) begin n_err++; $display("FAIL addi_ir_en_noack: got %b want 0", ir_en); end
    nxt(); imem_ack = 1'b1; instr = ADDI; #1;
    n_cmp++; if (ir_en !== 1'b1) begin n_err++; $display("FAIL addi_ir_en: got %b want 1", ir_en); end
    nxt(); imem_ack = 1'b0; #1;
    n_cmp++; if (state !== 3'd2) begin n_err++; $display("FAIL addi_decode_state: got %0d want 2", state); end
    n_cmp++; if (alu_op !== 2'b00) begin n_err++; $display("FAIL addi_decode_aluop: got %b want 00", alu_op); end
    nxt(); #1;
    n_cmp++; if (state !== 3'd3) begin n_err++; $display("FAIL addi_exec_state: got %0d want 3", state); end
    n_cmp++; if ({alu_op, alu_src} !== 3'b111) begin n_err++; $display("FAIL addi_exec_alu: got %b want 111", {alu_op, alu_src}); end
    n_cmp++; if ({mul_start, reg_write} !== 2'b00) begin n_err++; $display("FAIL addi_exec_strobes: got %b want 00", {mul_start, reg_write}); end
    nxt(); halt_req = 1'b1; #1;
    n_cmp++; if (state !== 3'd5) begin n_err++; $display("FAIL addi_wb_state: got %0d want 5", state); end
    n_cmp++; if ({reg_write, pc_en} !== 2'b11) begin n_err++; $display("FAIL addi_wb_pulse: got %b want 11", {reg_write, pc_en}); end
    n_cmp++; if ({alu_op, alu_src} !== 3'b111) begin n_err++; $display("FAIL addi_wb_alu: got %b want 111", {alu_op, alu_src}); end
    nxt(); halt_req = 1'b0; #1;
    n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL addi_idle_state: got %0d want 0", state); end
    n_cmp++; if ({reg_write, pc_en, alu_op} !== 4'b0000) begin n_err++; $display("FAIL addi_idle_strobes: got %b want 0000", {reg_write, pc_en, alu_op}); end
    n_cmp++; if (cnt !== 16'd1) begin n_err++; $display("FAIL addi_cnt: got %0d want 1", cnt); end
  endtask

  task automatic test_mul();
    int n_pulse;
    reset_dut(); start = 1'b1;
    nxt(); start = 1'b0; imem_ack = 1'b1; instr = ADD;
    nxt(); imem_ack = 1'b0;
    nxt(); #1;
    n_cmp++; if ({state, alu_op, alu_src, mul_start} !== {3'd3, 2'b10, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL add_exec: got %b want 011_10_0_0", {state, alu_op, alu_src, mul_start}); end
    nxt(); #1;
    n_cmp++; if ({state, reg_write} !== {3'd5, 1'b1}) begin n_err++; $display("FAIL add_wb: got %b want 101_1", {state, reg_write}); end
    nxt(); imem_ack = 1'b1; instr = MUL; #1;
    n_cmp++; if ({state, ir_en} !== {3'd1, 1'b1}) begin n_err++; $display("FAIL mul_fetch: got %b want 001_1", {state, ir_en}); end
    nxt(); imem_ack = 1'b0;
    nxt(); #1;
    n_pulse = int'(mul_start);
    n_cmp++; if ({state, alu_op, mul_start} !== {3'd3, 2'b10, 1'b1}) begin
      n_err++; $display("FAIL mul_exec: got %b want 011_10_1", {state, alu_op, mul_start}); end
    for (int i = 1; i <= 5; i++) begin
      nxt(); if (i == 5) mul_done = 1'b1; #1;
      n_pulse += int'(mul_start);
      n_cmp++; if ({state, alu_op, reg_write} !== {3'd4, 2'b10, 1'b0}) begin
        n_err++; $display("FAIL mulw_hold%0d: got %b want 100_10_0", i, {state, alu_op, reg_write}); end
    end
    nxt(); mul_done = 1'b0; halt_req = 1'b1; #1;
    n_pulse += int'(mul_start);
    n_cmp++; if ({state, reg_write, pc_en} !== {3'd5, 2'b11}) begin
      n_err++; $display("FAIL mul_wb: got %b want 101_11", {state, reg_write, pc_en}); end
    nxt(); halt_req = 1'b0; #1;
    n_cmp++; if (cnt !== 16'd2) begin n_err++; $display("FAIL mul_cnt: got %0d want 2", cnt); end
    n_cmp++; if (n_pulse !== 1) begin n_err++; $display("FAIL mul_start_pulses: got %0d want 1", n_pulse); end
  endtask

  task automatic test_illegal();
    reset_dut(); start = 1'b1;
    nxt(); start = 1'b0; imem_ack = 1'b1; instr = BAD;
    nxt(); imem_ack = 1'b0;
    nxt(); #1;
    n_cmp++; if ({state, illegal, reg_write} !== {3'd6, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL illegal_halt: got %b want 110_1_0", {state, illegal, reg_write}); end
    start = 1'b1;
    repeat (3) nxt();
    #1;
    n_cmp++; if ({state, illegal, imem_req, fetch_err} !== {3'd6, 1'b1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL illegal_sticky: got %b want 110_1_0_0", {state, illegal, imem_req, fetch_err}); end
    start = 1'b0;
  endtask

  task automatic test_timeout();
    reset_dut(); start = 1'b1;
    nxt(); start = 1'b0;
    repeat (15) nxt();
    #1;
    n_cmp++; if ({state, fetch_err} !== {3'd1, 1'b0}) begin n_err++; $display("FAIL tmo_cycle16: got %b want 001_0", {state, fetch_err}); end
    nxt(); #1;
    n_cmp++; if ({state, fetch_err, illegal} !== {3'd6, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL tmo_expired: got %b want 110_1_0", {state, fetch_err, illegal}); end
    reset_dut(); start = 1'b1;
    nxt(); start = 1'b0;
    repeat (15) nxt();
    imem_ack = 1'b1; instr = ADDI; #1;
    n_cmp++; if (ir_en !== 1'b1) begin n_err++; $display("FAIL tmo_late_ack_ir_en: got %b want 1", ir_en); end
    nxt(); imem_ack = 1'b0; #1;
    n_cmp++; if ({state, fetch_err} !== {3'd2, 1'b0}) begin n_err++; $display("FAIL tmo_late_ack: got %b want 010_0", {state, fetch_err}); end
  endtask

  task automatic test_zero_instr();
    reset_dut(); start = 1'b1;
    nxt(); start = 1'b0; imem_ack = 1'b1; instr = 32'h0;
    nxt(); imem_ack = 1'b0;
    nxt(); #1;
    n_cmp++; if ({state, illegal, fetch_err, reg_write} !== {3'd6, 3'b000}) begin
      n_err++; $display("FAIL zero_halt: got %b want 110_000", {state, illegal, fetch_err, reg_write}); end
  endtask

  task automatic test_reset_in_mulw();
    reset_dut(); start = 1'b1;
    nxt(); start = 1'b0;
    do_instr(ADDI, 1'b0);
    imem_ack = 1'b1; instr = MUL;
    nxt(); imem_ack = 1'b0;
    nxt();
    nxt(); #1;
    n_cmp++; if ({state, cnt} !== {3'd4, 16'd1}) begin n_err++; $display("FAIL rst_pre_mulw: got %0d/%0d want 4/1", state, cnt); end
    rst = 1'b1;
    nxt(); rst = 1'b0; #1;
    n_cmp++; if ({state, cnt} !== {3'd0, 16'd0}) begin n_err++; $display("FAIL rst_mulw_state_cnt: got %0d/%0d want 0/0", state, cnt); end
    n_cmp++; if ({imem_req, ir_en, alu_op, alu_src, mul_start, reg_write, pc_en, illegal, fetch_err} !== 10'h000) begin
      n_err++; $display("FAIL rst_mulw_outputs: got %b want 0", {imem_req, ir_en, alu_op, alu_src, mul_start, reg_write, pc_en, illegal, fetch_err}); end
    nxt(); #1;
    n_cmp++; if ({state, reg_write} !== {3'd0, 1'b0}) begin n_err++; $display("FAIL rst_mulw_no_wb: got %b want 000_0", {state, reg_write}); end
  endtask

  task automatic test_back_to_back();
    reset_dut(); start = 1'b1;
    nxt(); start = 1'b0;
    do_instr(ADDI, 1'b0); #1;
    n_cmp++; if ({state, imem_req} !== {3'd1, 1'b1}) begin n_err++; $display("FAIL b2b_refetch: got %b want 001_1", {state, imem_req}); end
    do_instr(ADD, 1'b1); #1;
    n_cmp++; if ({state, cnt} !== {3'd0, 16'd2}) begin n_err++; $display("FAIL b2b_halt_req: got %0d/%0d want 0/2", state, cnt); end
    nxt(); #1;
    n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL b2b_stay_idle: got %0d want 0", state); end
  endtask

  task automatic test_saturate();
    reset_dut(); start = 1'b1;
    nxt(); start = 1'b0;
    for (int i = 0; i < 3; i++) do_instr(ADDI, 1'b0);
    #1;
    n_cmp++; if (cnt_s !== 2'd3) begin n_err++; $display("FAIL sat_at3: got %0d want 3", cnt_s); end
    do_instr(ADDI, 1'b0);
    do_instr(ADDI, 1'b1); #1;
    n_cmp++; if (cnt !== 16'd5) begin n_err++; $display("FAIL sat_wide_cnt: got %0d want 5", cnt); end
    n_cmp++; if (cnt_s !== 2'd3) begin n_err++; $display("FAIL sat_narrow_cnt: got %0d want 3", cnt_s); end
    n_cmp++; if (state_s !== 3'd0) begin n_err++; $display("FAIL sat_state: got %0d want 0", state_s); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_mul();
    test_illegal();
    test_timeout();
    test_zero_instr();
    test_reset_in_mulw();
    test_back_to_back();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
